// File: rtl/cvbs_syncgen.sv
// Composite video sync generator: horizontal/vertical counters plus a registered
// level stage that produces 6-bit CVBS with field sync, line sync and picture.
module cvbs_syncgen #(
   parameter int LINE_CLKS    = 1536,
   parameter int LINES        = 312,
   parameter int FPORCH       = 40,
   parameter int HS           = 113,
   parameter int BPORCH       = 137,
   parameter int SSYNC        = 48,
   parameter int LSYNC        = 720,
   parameter int VLONG        = 672,
   parameter int BLACK        = 12,
   parameter int FIRST_ACTIVE = 23
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic        vecmode,
   input  logic [5:0]  pix,
   output logic [5:0]  cvbs,
   output logic        hsync,
   output logic        vsync,
   output logic        active,
   output logic [10:0] hcount,
   output logic [8:0]  vcount
);

   localparam logic [10:0] H_LAST  = 11'(LINE_CLKS - 1);
   localparam logic [8:0]  V_LAST  = 9'(LINES - 1);
   localparam logic [10:0] H_HALF  = 11'(LINE_CLKS / 2);
   localparam logic [10:0] H_LSYNC = 11'(LSYNC);
   localparam logic [10:0] H_SSYNC = 11'(SSYNC);
   localparam logic [10:0] H_VLONG = 11'(VLONG);
   localparam logic [10:0] H_HS0   = 11'(FPORCH);
   localparam logic [10:0] H_HS1   = 11'(FPORCH + HS);
   localparam logic [10:0] H_ACT   = 11'(FPORCH + HS + BPORCH);
   localparam logic [8:0]  V_ACT   = 9'(FIRST_ACTIVE);
   localparam logic [5:0]  C_BLACK = 6'(BLACK);

   logic        mode;
   logic [5:0]  cvbs_n;
   logic        hsync_n;
   logic        vsync_n;
   logic        active_n;
   logic        tip;
   logic        in_first_half;
   logic [10:0] h_half_off;
   logic [6:0]  pix_sum;

   always_comb begin
      in_first_half = hcount < H_HALF;
      h_half_off    = hcount - H_HALF;
      pix_sum       = {1'b0, pix} + 7'(BLACK);
      cvbs_n        = C_BLACK;
      hsync_n       = 1'b0;
      vsync_n       = 1'b0;
      active_n      = 1'b0;
      tip           = 1'b0;
      if (!mode && vcount <= 9'd5) begin
         // Lines 0-2 open with a broad pulse; line 2 switches to equalising mid-line.
         vsync_n = 1'b1;
         if (in_first_half)
            tip = (vcount <= 9'd2) ? (hcount < H_LSYNC) : (hcount < H_SSYNC);
         else
            tip = (vcount <= 9'd1) ? (h_half_off < H_LSYNC) : (h_half_off < H_SSYNC);
         if (tip)
            cvbs_n = 6'd0;
      end else if (mode && vcount <= 9'd2) begin
         vsync_n = 1'b1;
         if (hcount < H_VLONG)
            cvbs_n = 6'd0;
      end else if (hcount >= H_HS0 && hcount < H_HS1) begin
         cvbs_n  = 6'd0;
         hsync_n = 1'b1;
      end else if (hcount >= H_ACT && vcount >= V_ACT) begin
         active_n = 1'b1;
         cvbs_n   = pix_sum[6] ? 6'd63 : pix_sum[5:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hcount <= '0;
         vcount <= '0;
         mode   <= vecmode;
         cvbs   <= C_BLACK;
         hsync  <= 1'b0;
         vsync  <= 1'b0;
         active <= 1'b0;
      end else if (ce) begin
         cvbs   <= cvbs_n;
         hsync  <= hsync_n;
         vsync  <= vsync_n;
         active <= active_n;
         if (hcount == H_LAST) begin
            hcount <= '0;
            if (vcount == V_LAST) begin
               vcount <= '0;
               mode   <= vecmode;
            end else begin
               vcount <= vcount + 9'd1;
            end
         end else begin
            hcount <= hcount + 11'd1;
         end
      end
   end

endmodule

// File: tb/tb_cvbs_syncgen.sv
// Bench for cvbs_syncgen: a full-width instance (short field) and a scaled instance,
// both compared every clock against a position-based model of the sync rules.
module tb_cvbs_syncgen;

   typedef struct {
      int lc, lines, fp, hs, bp, ss, ls, vl, black, first;
   } timing_t;

   typedef struct {
      bit valid;
      int n, fmode, c, hs, vs, act, lh, lv;
   } model_t;

   typedef struct {
      int phase, v, h, c, hs, vs, act;
   } lit_t;

   timing_t tb_big   = '{1536, 32, 40, 113, 137, 48, 720, 672, 12, 23};
   timing_t tb_small = '{96, 12, 4, 8, 10, 3, 40, 42, 12, 8};

   lit_t lits[24] = '{
      '{1, 0, 0, 0, 0, 1, 0},     '{1, 0, 671, 0, 0, 1, 0},   '{1, 0, 672, 12, 0, 1, 0},
      '{1, 2, 671, 0, 0, 1, 0},   '{1, 3, 39, 12, 0, 0, 0},   '{1, 3, 40, 0, 1, 0, 0},
      '{1, 3, 152, 0, 1, 0, 0},   '{1, 3, 153, 12, 0, 0, 0},  '{2, 0, 719, 0, 0, 1, 0},
      '{2, 0, 720, 12, 0, 1, 0},  '{2, 0, 768, 0, 0, 1, 0},   '{2, 1, 1487, 0, 0, 1, 0},
      '{2, 1, 1488, 12, 0, 1, 0}, '{2, 2, 800, 0, 0, 1, 0},   '{2, 2, 816, 12, 0, 1, 0},
      '{2, 3, 47, 0, 0, 1, 0},    '{2, 3, 48, 12, 0, 1, 0},   '{2, 3, 815, 0, 0, 1, 0},
      '{2, 3, 816, 12, 0, 1, 0},  '{2, 6, 40, 0, 1, 0, 0},    '{2, 20, 500, 12, 0, 0, 0},
      '{2, 30, 289, 12, 0, 0, 0}, '{2, 30, 290, 32, 0, 0, 1}, '{2, 30, 1000, 63, 0, 0, 1}
   };

   logic        clk;
   logic        big_reset, big_ce, big_vm;
   logic [5:0]  big_pix, big_cvbs;
   logic        big_hsync, big_vsync, big_active;
   logic [10:0] big_hcount;
   logic [8:0]  big_vcount;
   logic        small_reset, small_ce, small_vm;
   logic [5:0]  small_pix, small_cvbs;
   logic        small_hsync, small_vsync, small_active;
   logic [10:0] small_hcount;
   logic [8:0]  small_vcount;

   int     checks = 0;
   int     failures = 0;
   int     cyc = 0;
   int     big_phase = 0;
   int     small_phase = 0;
   int     last_rise = -1;
   bit     s_prev_hs = 0;
   model_t mb, ms;

   cvbs_syncgen #(.LINES(32)) u_big (
      .clk(clk), .reset(big_reset), .ce(big_ce), .vecmode(big_vm), .pix(big_pix),
      .cvbs(big_cvbs), .hsync(big_hsync), .vsync(big_vsync), .active(big_active),
      .hcount(big_hcount), .vcount(big_vcount)
   );

   cvbs_syncgen #(
      .LINE_CLKS(96), .LINES(12), .FPORCH(4), .HS(8), .BPORCH(10), .SSYNC(3),
      .LSYNC(40), .VLONG(42), .BLACK(12), .FIRST_ACTIVE(8)
   ) u_small (
      .clk(clk), .reset(small_reset), .ce(small_ce), .vecmode(small_vm), .pix(small_pix),
      .cvbs(small_cvbs), .hsync(small_hsync), .vsync(small_vsync), .active(small_active),
      .hcount(small_hcount), .vcount(small_vcount)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   function automatic void ref_level(input timing_t t, input int h, input int v, input int mode,
                                     input int px, output int c, output int hs, output int vs,
                                     output int act);
      int  half;
      bit  tip;
      half = t.lc / 2;
      c = t.black; hs = 0; vs = 0; act = 0;
      if (mode == 0 && v <= 5) begin
         vs = 1;
         if (v <= 1)
            tip = (h < t.ls) || (h >= half && h < half + t.ls);
         else if (v == 2)
            tip = (h < half && h < t.ls) || (h >= half && h < half + t.ss);
         else
            tip = (h < t.ss) || (h >= half && h < half + t.ss);
         if (tip) c = 0;
      end else if (mode == 1 && v <= 2) begin
         vs = 1;
         if (h < t.vl) c = 0;
      end else if (h >= t.fp && h < t.fp + t.hs) begin
         c = 0;
         hs = 1;
      end else if (h >= t.fp + t.hs + t.bp && v >= t.first) begin
         act = 1;
         c = (t.black + px > 63) ? 63 : t.black + px;
      end
   endfunction

   // The model only tracks how many enabled cycles passed since reset and which
   // mode governs the current field; line/position follow by division.
   function automatic model_t advance(input model_t m, input timing_t t, input logic rst,
                                      input logic ce, input logic vm, input logic [5:0] px);
      model_t r;
      int     h, v;
      r = m;
      if (rst) begin
         r.valid = 1; r.n = 0; r.fmode = int'(vm);
         r.c = t.black; r.hs = 0; r.vs = 0; r.act = 0; r.lh = -1; r.lv = -1;
      end else if (ce && r.valid) begin
         h = r.n % t.lc;
         v = (r.n / t.lc) % t.lines;
         ref_level(t, h, v, r.fmode, int'(px), r.c, r.hs, r.vs, r.act);
         r.lh = h;
         r.lv = v;
         if (h == t.lc - 1 && v == t.lines - 1) r.fmode = int'(vm);
         r.n++;
      end
      return r;
   endfunction

   initial begin
      mb.valid = 0;
      ms.valid = 0;
   end

   always @(posedge clk) begin
      cyc++;
      mb = advance(mb, tb_big, big_reset, big_ce, big_vm, big_pix);
      ms = advance(ms, tb_small, small_reset, small_ce, small_vm, small_pix);
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mb.valid) begin
         check("big_cvbs", int'(big_cvbs), mb.c);
         check("big_hsync", int'(big_hsync), mb.hs);
         check("big_vsync", int'(big_vsync), mb.vs);
         check("big_active", int'(big_active), mb.act);
         check("big_hcount", int'(big_hcount), mb.n % tb_big.lc);
         check("big_vcount", int'(big_vcount), (mb.n / tb_big.lc) % tb_big.lines);
         check("big_hv_excl", int'(big_hsync & big_vsync), 0);
         foreach (lits[i]) begin
            if (lits[i].phase == big_phase && lits[i].v == mb.lv && lits[i].h == mb.lh) begin
               check($sformatf("lit_p%0d_v%0d_h%0d_cvbs", big_phase, mb.lv, mb.lh),
                     int'(big_cvbs), lits[i].c);
               check($sformatf("lit_p%0d_v%0d_h%0d_hsync", big_phase, mb.lv, mb.lh),
                     int'(big_hsync), lits[i].hs);
               check($sformatf("lit_p%0d_v%0d_h%0d_vsync", big_phase, mb.lv, mb.lh),
                     int'(big_vsync), lits[i].vs);
               check($sformatf("lit_p%0d_v%0d_h%0d_active", big_phase, mb.lv, mb.lh),
                     int'(big_active), lits[i].act);
            end
         end
      end
      if (ms.valid) begin
         check("small_cvbs", int'(small_cvbs), ms.c);
         check("small_hsync", int'(small_hsync), ms.hs);
         check("small_vsync", int'(small_vsync), ms.vs);
         check("small_active", int'(small_active), ms.act);
         check("small_hcount", int'(small_hcount), ms.n % tb_small.lc);
         check("small_vcount", int'(small_vcount), (ms.n / tb_small.lc) % tb_small.lines);
         check("small_hv_excl", int'(small_hsync & small_vsync), 0);
      end
      // With ce at half rate a line must span exactly twice its clock count.
      if (small_phase != 2) begin
         last_rise = -1;
      end else if (small_hsync && !s_prev_hs) begin
         if (last_rise >= 0 && ms.lv >= 7)
            check("small_line_period", cyc - last_rise, 2 * tb_small.lc);
         last_rise = cyc;
      end
      s_prev_hs = small_hsync;
   end

   // ---------------- drivers ----------------
   task automatic drive_big();
      int h, v;
      big_phase = 1;
      big_reset = 1'b1; big_ce = 1'b0; big_vm = 1'b1; big_pix = 6'd0;
      @(posedge clk); #1;
      // vecmode drops right after reset: the latched vector mode must persist.
      big_reset = 1'b0; big_ce = 1'b1; big_vm = 1'b0;
      for (int i = 0; i < 4 * 1536 + 8; i++) begin
         big_pix = 6'($urandom_range(0, 63));
         @(posedge clk); #1;
      end
      big_phase = 2;
      big_reset = 1'b1; big_vm = 1'b0;
      @(posedge clk); #1;
      big_reset = 1'b0;
      for (int i = 0; i < 31 * 1536; i++) begin
         h = mb.n % 1536;
         v = (mb.n / 1536) % 32;
         if (v == 30) big_pix = (h < 700) ? 6'd20 : 6'd60;
         else big_pix = 6'($urandom_range(0, 63));
         big_vm = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      big_phase = 3;
   endtask

   task automatic small_run(input int cycles, input int ce_style);
      int flip_n;
      flip_n = -1;
      for (int i = 0; i < cycles; i++) begin
         case (ce_style)
            0: small_ce = 1'b1;
            1: small_ce = ~small_ce;
            default: small_ce = ($urandom_range(0, 3) != 0);
         endcase
         small_pix = 6'($urandom_range(0, 63));
         // Flip the requested mode mid-field (line 6) so every field alternates.
         if (ms.n % 96 == 0 && (ms.n / 96) % 12 == 6 && ms.n != flip_n) begin
            small_vm = ~small_vm;
            flip_n = ms.n;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic drive_small();
      int  guard;
      small_phase = 1;
      small_reset = 1'b1; small_ce = 1'b1; small_vm = 1'b0; small_pix = 6'd0;
      @(posedge clk); #1;
      small_reset = 1'b0;
      small_run(3 * 1152, 0);
      small_phase = 2;
      small_run(2 * 2 * 1152, 1);
      small_phase = 3;
      small_run(2 * 1152, 2);
      small_phase = 4;
      small_ce = 1'b1;
      guard = 0;
      while (!((ms.n / 96) % 12 == 7 && ms.n % 96 == 50) && guard < 3000) begin
         small_pix = 6'($urandom_range(0, 63));
         @(posedge clk); #1;
         guard++;
      end
      check("small_reach_reset_point", int'(guard < 3000), 1);
      small_reset = 1'b1; small_ce = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      small_reset = 1'b0;
      small_run(3 * 1152, 0);
      small_phase = 5;
   endtask

   initial begin
      fork
         drive_big();
         drive_small();
      join
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cvbs_syncgen.md
CVBS_SYNCGEN -- requirements
Module: cvbs_syncgen

Interface
REQ-001 Parameter LINE_CLKS, default 1536, clocks per line (64 us at 24 MHz).
REQ-002 Parameter LINES, default 312, lines per field.
REQ-003 Parameter FPORCH, default 40, front porch clocks.
REQ-004 Parameter HS, default 113, horizontal sync clocks.
REQ-005 Parameter BPORCH, default 137, back porch clocks.
REQ-006 Parameter SSYNC, default 48, short (equalising) sync clocks.
REQ-007 Parameter LSYNC, default 720, long (broad) sync clocks.
REQ-008 Parameter VLONG, default 672, vector-mode vertical sync clocks.
REQ-009 Parameter BLACK, default 12, black level code.
REQ-010 Parameter FIRST_ACTIVE, default 23, first line carrying picture.
REQ-011 clk  in  1  master clock; all logic on its rising edge.
REQ-012 reset  in  1  synchronous, active-high reset.
REQ-013 ce  in  1  clock enable; counters and outputs update only when ce=1.
REQ-014 vecmode  in  1  0 = standard field sync, 1 = vector-style long sync.
REQ-015 pix  in  6  picture level above black, sampled during active video.
REQ-016 cvbs  out  6  composite level: 0 = sync tip, BLACK = blank.
REQ-017 hsync  out  1  high during horizontal sync tip on non-vsync lines.
REQ-018 vsync  out  1  high throughout field-sync lines.
REQ-019 active  out  1  high when cvbs carries pix.
REQ-020 hcount  out  11  clock position within line, 0..LINE_CLKS-1.
REQ-021 vcount  out  9  line within field, 0..LINES-1.

Function
REQ-022 hcount SHALL increment on each ce cycle and wrap from LINE_CLKS-1 to 0.
REQ-023 vcount SHALL increment on each hcount wrap and wrap from LINES-1 to 0.
REQ-024 vecmode SHALL be latched into an internal mode register only when vcount and hcount both wrap to 0; mid-field changes have no effect until the next field.
REQ-025 Outputs cvbs, hsync, vsync and active SHALL be registered and reflect the counter values of the previous ce cycle (1 ce-cycle latency).
REQ-026 Mode 0, lines 0-1: cvbs=0 for h<LSYNC and LINE_CLKS/2<=h<LINE_CLKS/2+LSYNC, else BLACK.
REQ-027 Mode 0, line 2: first half-line as REQ-026; second half-line sync lasts SSYNC.
REQ-028 Mode 0, lines 3-5: cvbs=0 for h<SSYNC and LINE_CLKS/2<=h<LINE_CLKS/2+SSYNC, else BLACK.
REQ-029 Mode 0: vsync=1 on lines 0-5.
REQ-030 Mode 1, lines 0-2: cvbs=0 for h<VLONG, else BLACK; vsync=1 on lines 0-2.
REQ-031 All other lines: cvbs=BLACK for h<FPORCH; cvbs=0 and hsync=1 for FPORCH<=h<FPORCH+HS; cvbs=BLACK for FPORCH+HS<=h<FPORCH+HS+BPORCH.
REQ-032 For h>=FPORCH+HS+BPORCH on lines >=FIRST_ACTIVE: active=1, cvbs=min(BLACK+pix, 63).
REQ-033 Same region on blanking lines (<FIRST_ACTIVE, non-vsync): cvbs=BLACK, active=0.
REQ-034 hsync and vsync SHALL never both be 1 in the same cycle.
REQ-035 When ce=0 all registers SHALL hold.

Reset
REQ-036 On reset=1 at a clock edge, regardless of ce: hcount=0, vcount=0, mode register=vecmode, cvbs=BLACK, hsync=0, vsync=0, active=0.
REQ-037 Reset mid-line or mid-field SHALL abandon the current line; the first ce cycle after reset deasserts starts line 0 at h=0.

Verification
REQ-038 Reset, ce=1, vecmode=0: cvbs=0 for 720 clocks from line 0 start, vsync=1; line 3 sync tips 48 clocks at h=0 and h=768.
REQ-039 vecmode=1 latched: lines 0-2 cvbs=0 for 672 clocks then 12; line 3 hsync=1 for 113 clocks starting h=40.
REQ-040 Line 30, pix=20 -> cvbs=32, active=1 from h=290; pix=60 -> cvbs=63 (saturation).
REQ-041 ce toggled 1/0 every cycle -> line period 3072 clocks, waveform identical to ce=1 when sampled on ce cycles.
REQ-042 vecmode flipped at line 100 -> current field unchanged; next field uses new mode.
REQ-043 Reset asserted at line 200, h=500 -> next cycle outputs at reset values, counters restart at 0; hsync and vsync never simultaneously 1 across 3 fields.
